acp_burst_slave_ram: RTL and testbench
======================================

Name: acp_burst_slave_ram

Overview:
- AXI burst responder (slave) backed by on-chip block RAM.
- It is the far end of the accelerator's 64-bit ACP-side AXI master port.
- Used as a deterministic memory target for accelerator bring-up and loopback, in place of the PS ACP port.
- The write channel (AW/W/B) and read channel (AR/R) are served by independent state machines sharing a dual-port RAM.

Parameters:
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 64, AXI data width; fixed at 64, with 8 strobe bits
- MEM_DEPTH_LOG2, 10, RAM depth in 64-bit words (1024 words = 8 KiB)
- BASE_ADDR, 32'h0000_0000, byte address of RAM word 0

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- S_AXI_AWADDR  in  32  write burst start address
- S_AXI_AWLEN  in  8  beats minus 1
- S_AXI_AWSIZE  in  3  beat size; only 3'b011 is legal
- S_AXI_AWBURST  in  2  00 FIXED, 01 INCR, others illegal
- S_AXI_AWCACHE / S_AXI_AWUSER / S_AXI_AWPROT  in  4/5/3  accepted, ignored
- S_AXI_AWVALID  in  1; S_AXI_AWREADY  out  1
- S_AXI_WDATA  in  64; S_AXI_WSTRB  in  8; S_AXI_WLAST  in  1
- S_AXI_WVALID  in  1; S_AXI_WREADY  out  1
- S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1
- S_AXI_ARADDR  in  32; S_AXI_ARLEN  in  8; S_AXI_ARSIZE  in  3; S_AXI_ARBURST  in  2
- S_AXI_ARCACHE / S_AXI_ARUSER / S_AXI_ARPROT  in  4/5/3  ignored
- S_AXI_ARVALID  in  1; S_AXI_ARREADY  out  1
- S_AXI_RDATA  out  64; S_AXI_RRESP  out  2; S_AXI_RLAST  out  1
- S_AXI_RVALID  out  1; S_AXI_RREADY  in  1

Behaviour:
- Reset:
  - All VALID/READY outputs, BRESP, RRESP, RDATA and RLAST are 0.
  - Both FSMs go to IDLE. RAM contents are not cleared.
  - Reset mid-burst aborts the burst with no further beats or response; words already written persist.
- Address mapping:
  - word index = ((addr - BASE_ADDR) >> 3) mod 2^MEM_DEPTH_LOG2.
  - addr[2:0] is ignored.
  - A start address outside [BASE_ADDR, BASE_ADDR + 8*2^MEM_DEPTH_LOG2) gives DECERR (2'b11).
  - INCR adds 1 per beat; the index wraps modulo depth and never errors mid-burst. FIXED holds the index.
- Illegal SIZE or BURST gives SLVERR (2'b10). DECERR takes priority over SLVERR.
- Write FSM, states W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1 from the first cycle after reset. On the AW handshake, latch index, count = AWLEN and error code; go to W_DATA. AWREADY drops the next cycle.
  - W_DATA: WREADY=1. Each W handshake writes the bytes enabled by WSTRB, unless an error is latched or more than AWLEN+1 beats have been received (extra beats are consumed but not written).
  - W_DATA, on a handshake with WLAST=1: go to W_RESP.
  - Response code: OKAY unless a latched error exists or the beat count != AWLEN+1 (then SLVERR).
  - W_RESP: BVALID=1 with BRESP held until BREADY, then go to W_IDLE. Earliest next AWREADY is the cycle after the B handshake.
- Read FSM, states R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. On the AR handshake in cycle N, the first RVALID is in cycle N+2 (synchronous RAM read plus output register).
  - R_DATA streams AWLEN-equivalent ARLEN+1 beats.
  - RLAST=1 only on the final beat.
  - With RREADY held high: one beat per cycle, no bubbles.
  - With RVALID=1 and RREADY=0: RDATA, RRESP and RLAST hold stable. Use a prefetch/skid register.
  - On error: RDATA=0 and RRESP is the error code on every beat; the full ARLEN+1 beat count is still returned.
  - After the final beat's handshake, go to R_IDLE. ARREADY rises the next cycle.
- Concurrency:
  - Read and write proceed simultaneously.
  - Same-word read and write in the same cycle returns old data (read-first).
  - Only one outstanding burst per direction.

Test Plan:
- INCR write at BASE_ADDR+0x40, AWLEN=3, data 0x1111..0x4444, WSTRB=0xFF -> BRESP=OKAY. Read back with ARLEN=3 -> 4 beats matching, RLAST on beat 4, first RVALID 2 cycles after AR.
- Write 0xFFFF_FFFF_FFFF_FFFF, then write 0 with WSTRB=0x0F to the same word -> readback 0xFFFF_FFFF_0000_0000.
- Read ARLEN=7 with RREADY toggling 1,0,0,1,... -> 8 beats in order, RDATA stable while stalled, exactly one RLAST.
- Write at BASE_ADDR+0x2000 (out of range), AWLEN=1 -> 2 beats accepted, BRESP=DECERR, RAM unchanged. Read there -> RRESP=DECERR, RDATA=0 on each beat.
- AWLEN=3 with WLAST on beat 2 -> BRESP=SLVERR and only 2 words written. Then INCR burst from the last word, AWLEN=1 -> second beat lands in word 0.
- Assert rst during beat 2 of an AWLEN=7 write -> no BVALID; AWREADY=1 the cycle after rst deasserts; beat 1 is present in RAM.

Source files
------------

// File: rtl/acp_burst_slave_ram.sv
// AXI burst slave backed by a byte-writable dual-port block RAM.
// The write (AW/W/B) and read (AR/R) channels run independent FSMs over the shared RAM.
module acp_burst_slave_ram #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 64,
  parameter int                    MEM_DEPTH_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic [ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                S_AXI_AWLEN,
  input  logic [2:0]                S_AXI_AWSIZE,
  input  logic [1:0]                S_AXI_AWBURST,
  input  logic [3:0]                S_AXI_AWCACHE,
  input  logic [4:0]                S_AXI_AWUSER,
  input  logic [2:0]                S_AXI_AWPROT,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,

  input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                      S_AXI_WLAST,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,

  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,

  input  logic [ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                S_AXI_ARLEN,
  input  logic [2:0]                S_AXI_ARSIZE,
  input  logic [1:0]                S_AXI_ARBURST,
  input  logic [3:0]                S_AXI_ARCACHE,
  input  logic [4:0]                S_AXI_ARUSER,
  input  logic [2:0]                S_AXI_ARPROT,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,

  output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RLAST,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY
);

  localparam int IW    = MEM_DEPTH_LOG2;
  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;
  localparam logic [1:0]    RESP_DECERR = 2'b11;
  localparam logic [IW-1:0] IDX_ONE     = 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // Offset from the window base, one bit wider so an address below the base shows up as a borrow.
  logic [ADDR_WIDTH:0] aw_diff, ar_diff;
  logic [IW-1:0]       aw_idx, ar_idx;
  logic [1:0]          aw_err, ar_err;

  assign aw_diff = {1'b0, S_AXI_AWADDR} - {1'b0, BASE_ADDR};
  assign ar_diff = {1'b0, S_AXI_ARADDR} - {1'b0, BASE_ADDR};
  assign aw_idx  = aw_diff[IW+2:3];
  assign ar_idx  = ar_diff[IW+2:3];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    aw_err = RESP_OKAY;
    if (aw_diff[ADDR_WIDTH] || (aw_diff[ADDR_WIDTH-1:IW+3] != '0))
      aw_err = RESP_DECERR;
    else if ((S_AXI_AWSIZE != 3'b011) || S_AXI_AWBURST[1])
      aw_err = RESP_SLVERR;

    ar_err = RESP_OKAY;
    if (ar_diff[ADDR_WIDTH] || (ar_diff[ADDR_WIDTH-1:IW+3] != '0))
      ar_err = RESP_DECERR;
    else if ((S_AXI_ARSIZE != 3'b011) || S_AXI_ARBURST[1])
      ar_err = RESP_SLVERR;
  end

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWCACHE, S_AXI_AWUSER, S_AXI_AWPROT, aw_diff[2:0],
                       S_AXI_ARCACHE, S_AXI_ARUSER, S_AXI_ARPROT, ar_diff[2:0]};

  // ---------------- write channel ----------------
  w_state_t      w_state;
  logic [IW-1:0] w_idx;
  logic [7:0]    w_len;
  logic [8:0]    w_cnt;
  logic [1:0]    w_err;
  logic          w_fixed;
  logic          w_hs, mem_we;

  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign mem_we = !rst && w_hs && (w_err == RESP_OKAY) && (w_cnt <= {1'b0, w_len});

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state       <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      w_idx         <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_err         <= RESP_OKAY;
      w_fixed       <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          S_AXI_AWREADY <= 1'b1;
          if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b1;
            w_idx         <= aw_idx;
            w_len         <= S_AXI_AWLEN;
            w_cnt         <= '0;
            w_err         <= aw_err;
            w_fixed       <= (S_AXI_AWBURST == 2'b00);
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (w_cnt != '1) w_cnt <= w_cnt + 9'd1;
            if (!w_fixed) w_idx <= w_idx + IDX_ONE;
            if (S_AXI_WLAST) begin
              S_AXI_WREADY <= 1'b0;
              S_AXI_BVALID <= 1'b1;
              // w_cnt still holds the beats before this one, so a correct burst ends at w_cnt == w_len.
              if (w_err != RESP_OKAY)           S_AXI_BRESP <= w_err;
              else if (w_cnt != {1'b0, w_len})  S_AXI_BRESP <= RESP_SLVERR;
              else                              S_AXI_BRESP <= RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= RESP_OKAY;
            S_AXI_AWREADY <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read channel ----------------
  r_state_t      r_state;
  logic [IW-1:0] r_idx;
  logic [7:0]    r_left;
  logic [1:0]    r_err;
  logic          r_fixed;
  logic          pf_valid, pf_last;
  logic          out_accept, rd_en;
  logic [IW-1:0] rd_idx;
  logic [DATA_WIDTH-1:0] mem_q;

  assign out_accept = !S_AXI_RVALID || S_AXI_RREADY;

  // The RAM output register only reloads on rd_en, so it doubles as the prefetch slot behind RDATA.
  always_comb begin
    rd_en  = 1'b0;
    rd_idx = r_idx;
    if (!rst) begin
      if (r_state == R_IDLE) begin
        rd_en  = S_AXI_ARVALID && S_AXI_ARREADY;
        rd_idx = ar_idx;
      end else begin
        rd_en  = (r_left != 8'd0) && (!pf_valid || out_accept);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RLAST   <= 1'b0;
      r_idx         <= '0;
      r_left        <= '0;
      r_err         <= RESP_OKAY;
      r_fixed       <= 1'b0;
      pf_valid      <= 1'b0;
      pf_last       <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          S_AXI_ARREADY <= 1'b1;
          if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            S_AXI_ARREADY <= 1'b0;
            r_err         <= ar_err;
            r_fixed       <= (S_AXI_ARBURST == 2'b00);
            r_idx         <= (S_AXI_ARBURST == 2'b00) ? ar_idx : ar_idx + IDX_ONE;
            r_left        <= S_AXI_ARLEN;
            pf_valid      <= 1'b1;
            pf_last       <= (S_AXI_ARLEN == 8'd0);
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (out_accept) begin
            S_AXI_RVALID <= pf_valid;
            S_AXI_RDATA  <= (pf_valid && (r_err == RESP_OKAY)) ? mem_q : '0;
            S_AXI_RRESP  <= pf_valid ? r_err : RESP_OKAY;
            S_AXI_RLAST  <= pf_valid && pf_last;
          end
          if (rd_en) begin
            pf_valid <= 1'b1;
            pf_last  <= (r_left == 8'd1);
            r_left   <= r_left - 8'd1;
            if (!r_fixed) r_idx <= r_idx + IDX_ONE;
          end else if (out_accept) begin
            pf_valid <= 1'b0;
          end
          if (S_AXI_RVALID && S_AXI_RREADY && S_AXI_RLAST) begin
            S_AXI_ARREADY <= 1'b1;
            r_state       <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- RAM: byte-enable write port, read-first read port ----------------
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the RAM array has no reset; contents survive rst and the block maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (S_AXI_WSTRB[b]) mem[w_idx][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
      end
    end
    if (rd_en) mem_q <= mem[rd_idx];
  end

endmodule

// File: tb/tb_acp_burst_slave_ram.sv
// Scoreboard bench for acp_burst_slave_ram: tasks drive bursts and queue expected
// responses from a word-array memory model; a negedge monitor pops and compares.
module tb_acp_burst_slave_ram;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          LIMIT = 3000;

  logic        clk, rst;
  logic [31:0] S_AXI_AWADDR, S_AXI_ARADDR;
  logic [7:0]  S_AXI_AWLEN, S_AXI_ARLEN;
  logic [2:0]  S_AXI_AWSIZE, S_AXI_ARSIZE, S_AXI_AWPROT, S_AXI_ARPROT;
  logic [1:0]  S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_BRESP, S_AXI_RRESP;
  logic [3:0]  S_AXI_AWCACHE, S_AXI_ARCACHE;
  logic [4:0]  S_AXI_AWUSER, S_AXI_ARUSER;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY, S_AXI_WLAST;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY, S_AXI_RLAST;
  logic [63:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [7:0]  S_AXI_WSTRB;

  acp_burst_slave_ram #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN), .S_AXI_AWSIZE(S_AXI_AWSIZE),
    .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWCACHE(S_AXI_AWCACHE), .S_AXI_AWUSER(S_AXI_AWUSER),
    .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARSIZE(S_AXI_ARSIZE),
    .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARCACHE(S_AXI_ARCACHE), .S_AXI_ARUSER(S_AXI_ARUSER),
    .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  int          total = 0, bad = 0;
  int          cyc = 0;
  int          ar_cyc = 0;
  bit          lat_pending = 0;
  logic [63:0] model [DEPTH];
  rbeat_t      r_q[$];
  logic [1:0]  b_q[$];
  logic [63:0] wd [300];
  logic [7:0]  ws [300];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] m_err(input logic [31:0] a, input logic [2:0] sz, input logic [1:0] bu);
    longint off;
    off = longint'({32'h0, a}) - longint'({32'h0, BASE});
    if (off < 0 || off >= 8 * DEPTH) return 2'b11;
    if (sz != 3'd3 || bu > 2'd1)     return 2'b10;
    return 2'b00;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE;
    return int'(d[12:3]);
  endfunction

  // ---------------- monitor / scoreboard ----------------
  bit          stall_q = 0;
  logic [66:0] held;
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 0;
    end else begin
      if (lat_pending && S_AXI_RVALID) begin
        check("r_first_latency", 67'(cyc - ar_cyc), 67'd2);
        lat_pending = 0;
      end
      if (stall_q) check("r_stable_stall", {S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST}, held);
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (b_q.size() == 0) check("b_unexpected", 67'd1, 67'd0);
        else                 check("bresp", 67'(S_AXI_BRESP), 67'(b_q.pop_front()));
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (r_q.size() == 0) begin
          check("r_unexpected", 67'd1, 67'd0);
        end else begin
          rbeat_t e;
          e = r_q.pop_front();
          check("rdata", 67'(S_AXI_RDATA), 67'(e.data));
          check("rresp", 67'(S_AXI_RRESP), 67'(e.resp));
          check("rlast", 67'(S_AXI_RLAST), 67'(e.last));
        end
      end
      stall_q = S_AXI_RVALID && !S_AXI_RREADY;
      held    = {S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST};
    end
  end

  // ---------------- stimulus tasks (enter and leave #1 after a posedge) ----------------
  task automatic send_aw(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
    S_AXI_AWADDR = a; S_AXI_AWLEN = len; S_AXI_AWSIZE = sz; S_AXI_AWBURST = bu;
    S_AXI_AWVALID = 1'b1;
    for (int t = 0; t < LIMIT; t++) begin
      @(negedge clk);
      if (S_AXI_AWREADY) begin
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0;
        return;
      end
    end
    check("aw_timeout", 67'd1, 67'd0);
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0;
  endtask

  task automatic send_w(input int i, input bit last);
    S_AXI_WDATA = wd[i]; S_AXI_WSTRB = ws[i]; S_AXI_WLAST = last; S_AXI_WVALID = 1'b1;
    for (int t = 0; t < LIMIT; t++) begin
      @(negedge clk);
      if (S_AXI_WREADY) begin
        @(posedge clk); #1;
        return;
      end
    end
    check("w_timeout", 67'd1, 67'd0);
    @(posedge clk); #1;
  endtask

  // Apply beat i of a burst to the model; beats past len+1 or on an errored burst are dropped.
  task automatic model_beat(input logic [1:0] err, input int idx, input int i, input int len);
    if (err == 2'b00 && i <= len)
      for (int b = 0; b < 8; b++)
        if (ws[i][b]) model[idx][b*8 +: 8] = wd[i][b*8 +: 8];
  endtask

  task automatic do_write(input logic [31:0] a, input int len, input int nbeats,
                          input logic [2:0] sz, input logic [1:0] bu, input bit rand_bready);
    logic [1:0] err;
    int idx;
    err = m_err(a, sz, bu);
    idx = m_idx(a);
    for (int i = 0; i < nbeats; i++) begin
      model_beat(err, idx, i, len);
      if (bu == 2'b01) idx = (idx + 1) % DEPTH;
    end
    b_q.push_back(err != 2'b00 ? err : (nbeats != len + 1 ? 2'b10 : 2'b00));
    S_AXI_BREADY = rand_bready ? 1'($urandom_range(0, 1)) : 1'b1;
    send_aw(a, 8'(len), sz, bu);
    for (int i = 0; i < nbeats; i++) send_w(i, i == nbeats - 1);
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    for (int t = 0; t < LIMIT; t++) begin
      @(posedge clk);
      if (b_q.size() == 0) break;
      #1 S_AXI_BREADY = rand_bready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    #1 S_AXI_BREADY = 1'b1;
    if (b_q.size() != 0) begin
      check("b_timeout", 67'd1, 67'd0);
      b_q.delete();
    end
  endtask

  function automatic logic rready_at(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_read(input logic [31:0] a, input int len, input logic [2:0] sz,
                         input logic [1:0] bu, input int mode);
    logic [1:0] err;
    int idx, k;
    err = m_err(a, sz, bu);
    idx = m_idx(a);
    for (int i = 0; i <= len; i++) begin
      r_q.push_back('{data: (err != 2'b00) ? 64'h0 : model[idx], resp: err, last: (i == len)});
      if (bu == 2'b01) idx = (idx + 1) % DEPTH;
    end
    k = 0;
    S_AXI_RREADY = rready_at(mode, k);
    S_AXI_ARADDR = a; S_AXI_ARLEN = 8'(len); S_AXI_ARSIZE = sz; S_AXI_ARBURST = bu;
    S_AXI_ARVALID = 1'b1;
    for (int t = 0; t < LIMIT; t++) begin
      @(negedge clk);
      if (S_AXI_ARREADY) begin
        ar_cyc = cyc;
        lat_pending = 1;
        break;
      end
    end
    @(posedge clk); #1;
    S_AXI_ARVALID = 1'b0;
    for (int t = 0; t < LIMIT; t++) begin
      k++;
      S_AXI_RREADY = rready_at(mode, k);
      @(posedge clk);
      if (r_q.size() == 0) break;
      #1;
    end
    #1 S_AXI_RREADY = 1'b1;
    if (r_q.size() != 0) begin
      check("r_timeout", 67'd1, 67'd0);
      r_q.delete();
    end
  endtask

  task automatic rand_data(input int n, input bit rand_strb);
    for (int i = 0; i < n; i++) begin
      wd[i] = {$urandom(), $urandom()};
      ws[i] = rand_strb ? 8'($urandom_range(0, 255)) : 8'hFF;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = 3'd3; S_AXI_AWBURST = 2'b01;
    S_AXI_AWCACHE = 4'hF; S_AXI_AWUSER = 5'h1F; S_AXI_AWPROT = 3'h7; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = 3'd3; S_AXI_ARBURST = 2'b01;
    S_AXI_ARCACHE = 4'hA; S_AXI_ARUSER = 5'h0A; S_AXI_ARPROT = 3'h5; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 67'(S_AXI_AWREADY), 67'd0);
    check("rst_arready", 67'(S_AXI_ARREADY), 67'd0);
    check("rst_wready",  67'(S_AXI_WREADY),  67'd0);
    check("rst_valids",  67'({S_AXI_BVALID, S_AXI_RVALID}), 67'd0);
    check("rst_payload", {S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST}, 67'd0);
    check("rst_bresp",   67'(S_AXI_BRESP), 67'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("awready_after_rst", 67'(S_AXI_AWREADY), 67'd1);
    check("arready_after_rst", 67'(S_AXI_ARREADY), 67'd1);
    @(posedge clk); #1;

    // Fill the whole RAM so every later read has a known expected value.
    for (int blk = 0; blk < 4; blk++) begin
      rand_data(256, 0);
      do_write(BASE + 32'(blk * 2048), 255, 256, 3'd3, 2'b01, 0);
    end

    // Basic INCR write and readback at full rate.
    wd[0] = 64'h1111_1111_1111_1111; wd[1] = 64'h2222_2222_2222_2222;
    wd[2] = 64'h3333_3333_3333_3333; wd[3] = 64'h4444_4444_4444_4444;
    for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
    do_write(BASE + 32'h40, 3, 4, 3'd3, 2'b01, 0);
    do_read(BASE + 32'h40, 3, 3'd3, 2'b01, 0);

    // Byte strobes: lower half cleared, upper half kept.
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
    do_write(BASE + 32'h800, 0, 1, 3'd3, 2'b01, 0);
    wd[0] = 64'h0; ws[0] = 8'h0F;
    do_write(BASE + 32'h800, 0, 1, 3'd3, 2'b01, 0);
    do_read(BASE + 32'h800, 0, 3'd3, 2'b01, 0);

    // Back-pressured read, RREADY 1,0,0 repeating.
    do_read(BASE + 32'h100, 7, 3'd3, 2'b01, 1);

    // Out of window above and below the base: DECERR, RAM untouched.
    rand_data(2, 0);
    do_write(BASE + 32'h2000, 1, 2, 3'd3, 2'b01, 0);
    do_read(BASE + 32'h2000, 1, 3'd3, 2'b01, 0);
    do_read(BASE - 32'h8, 0, 3'd3, 2'b01, 0);
    do_read(BASE, 1, 3'd3, 2'b01, 0);

    // Early WLAST and extra beats: SLVERR, only in-range beats written.
    rand_data(4, 0);
    do_write(BASE + 32'h300, 3, 2, 3'd3, 2'b01, 0);
    do_read(BASE + 32'h300, 3, 3'd3, 2'b01, 0);
    rand_data(4, 0);
    do_write(BASE + 32'h400, 1, 3, 3'd3, 2'b01, 0);
    do_read(BASE + 32'h400, 3, 3'd3, 2'b01, 0);

    // INCR wrap from the last word into word 0, both directions.
    rand_data(2, 0);
    do_write(BASE + 32'h1FF8, 1, 2, 3'd3, 2'b01, 0);
    do_read(BASE + 32'h1FF8, 1, 3'd3, 2'b01, 0);
    do_read(BASE, 0, 3'd3, 2'b01, 0);

    // Illegal SIZE / BURST: SLVERR, nothing written, reads return zero data.
    rand_data(2, 0);
    do_write(BASE + 32'h500, 1, 2, 3'd2, 2'b01, 0);
    do_write(BASE + 32'h508, 0, 1, 3'd3, 2'b10, 0);
    do_read(BASE + 32'h500, 1, 3'd3, 2'b11, 0);
    do_read(BASE + 32'h500, 1, 3'd4, 2'b01, 0);
    do_read(BASE + 32'h500, 1, 3'd3, 2'b01, 0);

    // FIXED bursts hold the word index.
    rand_data(4, 1);
    do_write(BASE + 32'h600, 3, 4, 3'd3, 2'b00, 0);
    do_read(BASE + 32'h600, 2, 3'd3, 2'b00, 2);
    do_read(BASE + 32'h5F8, 2, 3'd3, 2'b01, 0);

    // Write and read channels running at the same time on disjoint words.
    rand_data(8, 1);
    fork
      do_write(BASE + 32'h700, 7, 8, 3'd3, 2'b01, 1);
      do_read(BASE + 32'hA00, 15, 3'd3, 2'b01, 2);
    join
    do_read(BASE + 32'h700, 7, 3'd3, 2'b01, 0);

    // Randomized in-window traffic.
    for (int n = 0; n < 30; n++) begin
      logic [31:0] a;
      int          len;
      logic [1:0]  bu;
      a   = BASE + (32'($urandom_range(0, DEPTH - 1)) << 3) + 32'($urandom_range(0, 7));
      len = $urandom_range(0, 15);
      bu  = 2'($urandom_range(0, 1));
      rand_data(len + 1, 1);
      do_write(a, len, len + 1, 3'd3, bu, 1);
      do_read(a, len, 3'd3, bu, 2);
    end

    // Reset in the middle of a write burst: no response, first beat kept.
    rand_data(2, 0);
    send_aw(BASE + 32'h900, 8'd7, 3'd3, 2'b01);
    model_beat(2'b00, m_idx(BASE + 32'h900), 0, 7);
    send_w(0, 0);
    S_AXI_WDATA = wd[1]; S_AXI_WSTRB = ws[1]; S_AXI_WVALID = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; S_AXI_WVALID = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("awready_post_abort", 67'(S_AXI_AWREADY), 67'd1);
    for (int i = 0; i < 4; i++) begin
      check("no_bvalid_after_abort", 67'(S_AXI_BVALID), 67'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    do_read(BASE + 32'h900, 1, 3'd3, 2'b01, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected under 100000", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
